// File: rtl/trace_filter_ctrl.sv
// Trace capture controller: filters instruction-trace beats into a small FIFO
// under a start/stop/drain/halt state machine, with saturating event counters.
module trace_filter_ctrl #(
    parameter int FIFO_DEPTH       = 4,
    parameter bit HALT_ON_OVERFLOW = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        clr,
    input  logic        bypass,
    input  logic        tr_valid,
    input  logic [63:0] tr_pc,
    input  logic [31:0] tr_instr,
    input  logic        drop_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    output logic [4:0]  fifo_count,
    output logic [1:0]  state,
    output logic [31:0] kept_cnt,
    output logic [31:0] dropped_cnt,
    output logic [31:0] overflow_cnt
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [4:0]      count_q, count_d;
    logic [63:0]     pc_mem_q    [FIFO_DEPTH];
    logic [63:0]     pc_mem_d    [FIFO_DEPTH];
    logic [31:0]     instr_mem_q [FIFO_DEPTH];
    logic [31:0]     instr_mem_d [FIFO_DEPTH];
    logic [31:0]     kept_q, kept_d;
    logic [31:0]     dropped_q, dropped_d;
    logic [31:0]     ovf_q, ovf_d;

    logic            pop_s, cand_s, drop_s, push_s, ovf_s;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Per-cycle capture decisions; a full FIFO still accepts when the head leaves this cycle.
    always_comb begin
        pop_s  = (count_q != 5'd0) && out_ready;
        cand_s = (state_q == ST_RUN) && tr_valid && (bypass || !drop_instr);
        drop_s = (state_q == ST_RUN) && tr_valid && !bypass && drop_instr;
        push_s = cand_s && ((count_q < 5'(FIFO_DEPTH)) || pop_s);
        ovf_s  = cand_s && !push_s;
    end

    // Next-state logic; clr overrides every transition.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !stop) state_d = ST_RUN;
                    else                state_d = ST_IDLE;
                end
                ST_RUN: begin
                    if (ovf_s && HALT_ON_OVERFLOW) state_d = ST_HALT;
                    else if (stop)                 state_d = ST_DRAIN;
                    else                           state_d = ST_RUN;
                end
                ST_DRAIN: begin
                    if (count_q == 5'd0) state_d = ST_IDLE;
                    else                 state_d = ST_DRAIN;
                end
                ST_HALT:  state_d = ST_HALT;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // FIFO storage, pointers, occupancy and event counters.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        kept_d      = kept_q;
        dropped_d   = dropped_q;
        ovf_d       = ovf_q;
        if (clr) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = 5'd0;
            kept_d    = 32'd0;
            dropped_d = 32'd0;
            ovf_d     = 32'd0;
        end else begin
            if (push_s) begin
                pc_mem_d[wr_ptr_q]    = tr_pc;
                instr_mem_d[wr_ptr_q] = tr_instr;
                wr_ptr_d              = wr_ptr_q + AW'(1'b1);
                kept_d                = sat_inc(kept_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + 5'd1;
                2'b01:   count_d = count_q - 5'd1;
                default: count_d = count_q;
            endcase
            if (drop_s) dropped_d = sat_inc(dropped_q);
            else        dropped_d = dropped_q;
            if (ovf_s)  ovf_d = sat_inc(ovf_q);
            else        ovf_d = ovf_q;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= 5'd0;
            kept_q    <= 32'd0;
            dropped_q <= 32'd0;
            ovf_q     <= 32'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem_q[i]    <= 64'd0;
                instr_mem_q[i] <= 32'd0;
            end
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            kept_q      <= kept_d;
            dropped_q   <= dropped_d;
            ovf_q       <= ovf_d;
            pc_mem_q    <= pc_mem_d;
            instr_mem_q <= instr_mem_d;
        end
    end

    assign out_valid    = (count_q != 5'd0);
    assign out_pc       = out_valid ? pc_mem_q[rd_ptr_q] : 64'd0;
    assign out_instr    = out_valid ? instr_mem_q[rd_ptr_q] : 32'd0;
    assign fifo_count   = count_q;
    assign state        = state_q;
    assign kept_cnt     = kept_q;
    assign dropped_cnt  = dropped_q;
    assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_trace_filter_ctrl.sv
// Self-checking bench: two instances (HALT_ON_OVERFLOW 0 and 1) against a
// list-based reference model, directed scenarios followed by random traffic.
module tb_trace_filter_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, start, stop, clr, bypass, tr_valid, drop_instr, out_ready;
    logic [63:0] tr_pc;
    logic [31:0] tr_instr;

    logic        ov_o  [2];
    logic [63:0] opc_o [2];
    logic [31:0] oin_o [2];
    logic [4:0]  cnt_o [2];
    logic [1:0]  st_o  [2];
    logic [31:0] kc_o  [2];
    logic [31:0] dc_o  [2];
    logic [31:0] oc_o  [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        trace_filter_ctrl #(.FIFO_DEPTH(4), .HALT_ON_OVERFLOW(g == 1)) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clr(clr),
            .bypass(bypass), .tr_valid(tr_valid), .tr_pc(tr_pc), .tr_instr(tr_instr),
            .drop_instr(drop_instr), .out_valid(ov_o[g]), .out_ready(out_ready),
            .out_pc(opc_o[g]), .out_instr(oin_o[g]), .fifo_count(cnt_o[g]),
            .state(st_o[g]), .kept_cnt(kc_o[g]), .dropped_cnt(dc_o[g]),
            .overflow_cnt(oc_o[g])
        );
    end

    // Reference model: m_list[i][0] is the oldest entry, entries shift down on a pop.
    logic [95:0] m_list [2][4];
    int          m_cnt  [2];
    int          m_st   [2];
    logic [31:0] m_kept [2];
    logic [31:0] m_drop [2];
    logic [31:0] m_ovf  [2];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat1(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit pop, cand, push, ovf;
            int cnt0;
            if (!rst_n || clr) begin
                m_cnt[i] = 0; m_st[i] = 0;
                m_kept[i] = 32'd0; m_drop[i] = 32'd0; m_ovf[i] = 32'd0;
            end else begin
                cnt0 = m_cnt[i];
                pop  = (cnt0 > 0) && out_ready;
                cand = (m_st[i] == 1) && tr_valid && (bypass || !drop_instr);
                if ((m_st[i] == 1) && tr_valid && !bypass && drop_instr) m_drop[i] = sat1(m_drop[i]);
                push = cand && (cnt0 < 4 || pop);
                ovf  = cand && !push;
                if (pop) begin
                    for (int k = 0; k < 3; k++) m_list[i][k] = m_list[i][k+1];
                    m_cnt[i]--;
                end
                if (push) begin
                    m_list[i][m_cnt[i]] = {tr_pc, tr_instr};
                    m_cnt[i]++;
                    m_kept[i] = sat1(m_kept[i]);
                end
                if (ovf) m_ovf[i] = sat1(m_ovf[i]);
                case (m_st[i])
                    0: if (start && !stop) m_st[i] = 1;
                    1: if (ovf && i == 1) m_st[i] = 3;
                       else if (stop) m_st[i] = 2;
                    2: if (cnt0 == 0) m_st[i] = 0;
                    default: m_st[i] = 3;
                endcase
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("d%0d_state", i), 64'(st_o[i]), 64'(m_st[i]));
            check_val($sformatf("d%0d_count", i), 64'(cnt_o[i]), 64'(m_cnt[i]));
            check_val($sformatf("d%0d_valid", i), 64'(ov_o[i]), 64'(m_cnt[i] != 0));
            check_val($sformatf("d%0d_pc", i), opc_o[i], (m_cnt[i] != 0) ? m_list[i][0][95:32] : 64'd0);
            check_val($sformatf("d%0d_instr", i), 64'(oin_o[i]), (m_cnt[i] != 0) ? 64'(m_list[i][0][31:0]) : 64'd0);
            check_val($sformatf("d%0d_kept", i), 64'(kc_o[i]), 64'(m_kept[i]));
            check_val($sformatf("d%0d_dropped", i), 64'(dc_o[i]), 64'(m_drop[i]));
            check_val($sformatf("d%0d_ovf", i), 64'(oc_o[i]), 64'(m_ovf[i]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        start = 1'b0; stop = 1'b0; clr = 1'b0;
    endtask

    task automatic beat(input logic [63:0] pc, input logic drop);
        tr_valid = 1'b1; tr_pc = pc; tr_instr = $urandom; drop_instr = drop;
        step();
        tr_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; clr = 1'b0; bypass = 1'b0;
        tr_valid = 1'b0; drop_instr = 1'b0; out_ready = 1'b0;
        tr_pc = 64'd0; tr_instr = 32'd0;
        for (int i = 0; i < 2; i++) m_cnt[i] = 0;
        step(); step();
        check_val("rst_state", 64'(st_o[0]), 64'd0);
        check_val("rst_pc", opc_o[0], 64'd0);
        rst_n = 1'b1;

        // Filter pass
        start = 1'b1; step();
        out_ready = 1'b1;
        beat(64'h100, 1'b1);
        beat(64'h104, 1'b0);
        check_val("filt_head0", opc_o[0], 64'h104);
        beat(64'h108, 1'b0);
        check_val("filt_head1", opc_o[0], 64'h108);
        step();
        check_val("filt_kept", 64'(kc_o[0]), 64'd2);
        check_val("filt_dropped", 64'(dc_o[0]), 64'd1);
        stop = 1'b1; step(); step();
        check_val("filt_idle", 64'(st_o[0]), 64'd0);

        // Overflow, halt, full-with-pop
        clr = 1'b1; step();
        start = 1'b1; step();
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) beat(64'h200 + 64'(4 * k), 1'b0);
        check_val("ovf_count", 64'(cnt_o[0]), 64'd4);
        check_val("ovf_cnt", 64'(oc_o[0]), 64'd2);
        check_val("halt_state", 64'(st_o[1]), 64'd3);
        check_val("halt_ovf", 64'(oc_o[1]), 64'd1);
        start = 1'b1; step();
        check_val("halt_ign_start", 64'(st_o[1]), 64'd3);
        out_ready = 1'b1;
        beat(64'h300, 1'b0);
        check_val("fullpop_count", 64'(cnt_o[0]), 64'd4);
        check_val("fullpop_ovf", 64'(oc_o[0]), 64'd2);
        check_val("fullpop_head", opc_o[0], 64'h204);
        for (int k = 0; k < 5; k++) step();
        clr = 1'b1; step();
        check_val("clr_state", 64'(st_o[1]), 64'd0);
        check_val("clr_kept", 64'(kc_o[1]), 64'd0);
        check_val("clr_count", 64'(cnt_o[1]), 64'd0);

        // Drain
        start = 1'b1; out_ready = 1'b0; step();
        for (int k = 0; k < 3; k++) beat(64'h400 + 64'(4 * k), 1'b0);
        stop = 1'b1; out_ready = 1'b1; step();
        check_val("drain_state", 64'(st_o[0]), 64'd2);
        tr_valid = 1'b1; drop_instr = 1'b0; tr_pc = 64'h4F0;
        step(); step();
        check_val("drain_empty_state", 64'(st_o[0]), 64'd2);
        step();
        tr_valid = 1'b0;
        check_val("drain_idle", 64'(st_o[0]), 64'd0);
        check_val("drain_kept", 64'(kc_o[0]), 64'd3);

        // Reset mid-run
        start = 1'b1; out_ready = 1'b0; step();
        beat(64'h500, 1'b0); beat(64'h504, 1'b0);
        check_val("rmid_count", 64'(cnt_o[0]), 64'd2);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        check_val("rmid_count0", 64'(cnt_o[0]), 64'd0);
        check_val("rmid_valid", 64'(ov_o[0]), 64'd0);
        start = 1'b1; step();
        beat(64'h600, 1'b0);
        check_val("rmid_resume_pc", opc_o[0], 64'h600);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            start      = ($urandom_range(0, 9) == 0);
            stop       = ($urandom_range(0, 24) == 0);
            clr        = ($urandom_range(0, 149) == 0);
            rst_n      = ($urandom_range(0, 299) != 0);
            bypass     = ($urandom_range(0, 3) == 0);
            tr_valid   = $urandom_range(0, 1);
            drop_instr = $urandom_range(0, 1);
            out_ready  = ($urandom_range(0, 2) != 0);
            tr_pc      = {$urandom, $urandom};
            tr_instr   = $urandom;
            @(posedge clk);
            model_step();
            #1;
            compare_all();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
